// File: rtl/cgmii_frame_gen_hs.sv
// cgmii_frame_gen_hs
// CGMII TX frame generator: ordered-set preamble, idle gaps, start/data/term
// blocks from a deterministic byte counter, valid/ready handshake toward the
// encoder, frame quota with done flag and single-block error injection.
//
// Ports:
//   i_clock      clock
//   i_reset      asynchronous active-low reset
//   i_enable     run enable
//   i_ndata      data blocks per frame (latched when START is accepted)
//   i_nidle      idle blocks per gap (latched on entry to the gap)
//   i_nterm      data bytes in the term block (latched when START is accepted)
//   i_err_req    request: replace the next presented block with an error block
//   i_ready      downstream ready
//   o_valid      block valid
//   o_tx_data    64-bit block, MSB byte is lane 0
//   o_tx_ctrl    control mask, MSB bit maps to lane 0
//   o_frame_cnt  completed frames (wraps)
//   o_done       frame quota reached
module cgmii_frame_gen_hs #(
    parameter int unsigned NB_DATA_RAW = 64,
    parameter int unsigned NB_CTRL_RAW = 8,
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_IDLE     = 5,
    parameter int unsigned NB_TERM     = 3,
    parameter int unsigned N_ORD       = 4,
    parameter int unsigned NB_FCNT     = 16,
    parameter int unsigned N_FRAMES    = 0
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [NB_DATA-1:0]     i_ndata,
    input  logic [NB_IDLE-1:0]     i_nidle,
    input  logic [NB_TERM-1:0]     i_nterm,
    input  logic                   i_err_req,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [NB_DATA_RAW-1:0] o_tx_data,
    output logic [NB_CTRL_RAW-1:0] o_tx_ctrl,
    output logic [NB_FCNT-1:0]     o_frame_cnt,
    output logic                   o_done
);

    typedef enum logic [1:0] {StOrd, StGap, StBody, StDone} state_e;

    localparam logic [NB_DATA_RAW-1:0] BLK_ORD   = NB_DATA_RAW'(64'h9C68797300000000);
    localparam logic [NB_DATA_RAW-1:0] BLK_START = NB_DATA_RAW'(64'hFB555555555555D5);
    localparam logic [NB_DATA_RAW-1:0] BLK_IDLE  = {NB_CTRL_RAW{8'h07}};
    localparam logic [NB_DATA_RAW-1:0] BLK_ERR   = {NB_CTRL_RAW{8'hFE}};
    localparam logic [NB_CTRL_RAW-1:0] CTRL_LANE0 = {1'b1, {(NB_CTRL_RAW-1){1'b0}}};
    localparam logic [NB_CTRL_RAW-1:0] CTRL_ALL   = {NB_CTRL_RAW{1'b1}};
    localparam logic [7:0]             ORD_LAST   = 8'(N_ORD - 1);

    state_e                 r_state;
    logic [7:0]             r_ord_cnt;
    logic [NB_IDLE-1:0]     r_idle_cnt;
    logic [NB_IDLE-1:0]     r_nidle;
    logic [NB_DATA-1:0]     r_data_cnt;
    logic [NB_DATA-1:0]     r_ndata;
    logic [NB_TERM-1:0]     r_nterm;
    logic [7:0]             r_byte_cnt;
    logic                   r_err_pend;
    logic                   r_valid;
    logic [NB_DATA_RAW-1:0] r_tx_data;
    logic [NB_CTRL_RAW-1:0] r_tx_ctrl;
    logic                   r_is_start;
    logic                   r_is_term;
    logic [NB_FCNT-1:0]     r_frame_cnt;
    logic                   r_done;

    state_e                 w_state_nxt;
    logic [7:0]             w_ord_cnt_nxt;
    logic [NB_IDLE-1:0]     w_idle_cnt_nxt;
    logic [NB_IDLE-1:0]     w_nidle_nxt;
    logic [NB_DATA-1:0]     w_data_cnt_nxt;
    logic [7:0]             w_byte_cnt_nxt;
    logic [NB_DATA_RAW-1:0] w_blk_data;
    logic [NB_CTRL_RAW-1:0] w_blk_ctrl;
    logic                   w_blk_start;
    logic                   w_blk_term;
    logic                   w_xfer;
    logic                   w_load;
    logic                   w_start_acc;
    logic [NB_DATA-1:0]     w_ndata;
    logic [NB_TERM-1:0]     w_nterm;
    logic                   w_last_frame;

    assign w_xfer      = r_valid & i_ready;
    // The output stage refills whenever it is empty or being drained; the FSM
    // state always describes the next block to generate.
    assign w_load      = i_enable & (~r_valid | i_ready);
    assign w_start_acc = w_xfer & r_is_start;
    // The block after START may be generated in the very cycle START is
    // accepted, before the latched copy is visible.
    assign w_ndata     = w_start_acc ? i_ndata : r_ndata;
    assign w_nterm     = w_start_acc ? i_nterm : r_nterm;
    assign w_last_frame = (N_FRAMES != 0) &&
                          ((r_frame_cnt + NB_FCNT'(1)) == NB_FCNT'(N_FRAMES));

    always_comb begin
        w_state_nxt    = r_state;
        w_ord_cnt_nxt  = r_ord_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        w_nidle_nxt    = r_nidle;
        w_data_cnt_nxt = r_data_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_blk_data     = BLK_IDLE;
        w_blk_ctrl     = CTRL_ALL;
        w_blk_start    = 1'b0;
        w_blk_term     = 1'b0;
        unique case (r_state)
            StOrd: begin
                w_blk_data = BLK_ORD;
                w_blk_ctrl = CTRL_LANE0;
                if (r_ord_cnt == ORD_LAST) begin
                    w_state_nxt    = StGap;
                    w_nidle_nxt    = i_nidle;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_ord_cnt_nxt = r_ord_cnt + 8'd1;
                end
            end
            StGap: begin
                if (r_idle_cnt == r_nidle) begin
                    w_blk_data     = BLK_START;
                    w_blk_ctrl     = CTRL_LANE0;
                    w_blk_start    = 1'b1;
                    w_state_nxt    = StBody;
                    w_data_cnt_nxt = '0;
                    w_byte_cnt_nxt = 8'd0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + NB_IDLE'(1);
                end
            end
            StBody: begin
                if (r_data_cnt == w_ndata) begin
                    for (int j = 0; j < int'(NB_CTRL_RAW); j++) begin
                        if (j < int'(w_nterm)) begin
                            w_blk_data[NB_DATA_RAW-1-8*j -: 8] = r_byte_cnt + 8'(j);
                        end else if (j == int'(w_nterm)) begin
                            w_blk_data[NB_DATA_RAW-1-8*j -: 8] = 8'hFD;
                        end else begin
                            w_blk_data[NB_DATA_RAW-1-8*j -: 8] = 8'h07;
                        end
                    end
                    w_blk_ctrl     = CTRL_ALL >> w_nterm;
                    w_blk_term     = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 8'(w_nterm);
                    if (w_last_frame) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt    = StGap;
                        w_nidle_nxt    = i_nidle;
                        w_idle_cnt_nxt = '0;
                    end
                end else begin
                    for (int j = 0; j < int'(NB_CTRL_RAW); j++) begin
                        w_blk_data[NB_DATA_RAW-1-8*j -: 8] = r_byte_cnt + 8'(j);
                    end
                    w_blk_ctrl     = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 8'(NB_CTRL_RAW);
                    w_data_cnt_nxt = r_data_cnt + NB_DATA'(1);
                end
            end
            StDone: begin
                w_blk_data = BLK_IDLE;
                w_blk_ctrl = CTRL_ALL;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StOrd;
            r_ord_cnt   <= 8'd0;
            r_idle_cnt  <= '0;
            r_nidle     <= '0;
            r_data_cnt  <= '0;
            r_ndata     <= '0;
            r_nterm     <= '0;
            r_byte_cnt  <= 8'd0;
            r_err_pend  <= 1'b0;
            r_valid     <= 1'b0;
            r_tx_data   <= '0;
            r_tx_ctrl   <= '0;
            r_is_start  <= 1'b0;
            r_is_term   <= 1'b0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_load) begin
                r_state    <= w_state_nxt;
                r_ord_cnt  <= w_ord_cnt_nxt;
                r_idle_cnt <= w_idle_cnt_nxt;
                r_nidle    <= w_nidle_nxt;
                r_data_cnt <= w_data_cnt_nxt;
                r_byte_cnt <= w_byte_cnt_nxt;
                r_valid    <= 1'b1;
                // An error block only swaps content; FSM and counters advance normally.
                r_tx_data  <= r_err_pend ? BLK_ERR : w_blk_data;
                r_tx_ctrl  <= r_err_pend ? CTRL_ALL : w_blk_ctrl;
                r_is_start <= w_blk_start;
                r_is_term  <= w_blk_term;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_start_acc) begin
                r_ndata <= i_ndata;
                r_nterm <= i_nterm;
            end
            // A loaded block is always accepted eventually, so consuming the
            // request at load is equivalent to clearing it on acceptance.
            r_err_pend <= i_err_req | (r_err_pend & ~w_load);
            if (w_xfer && r_is_term) begin
                r_frame_cnt <= r_frame_cnt + NB_FCNT'(1);
                if (w_last_frame) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_tx_data   = r_tx_data;
    assign o_tx_ctrl   = r_tx_ctrl;
    assign o_frame_cnt = r_frame_cnt;
    assign o_done      = r_done;

endmodule
